// File: rtl/move_list_store_if.sv
// Handshake and read-port bundle between move generator, consumer and store.
// master: generator/consumer side; slave: move_list_store.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

interface move_list_store_if #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = 16
);
    logic                          list_start;
    logic                          wr_valid;
    logic                          wr_ready;
    logic [`BOARD_WIDTH-1:0]       wr_board;
    logic [UCI_WIDTH-1:0]          wr_uci;
    logic signed [EVAL_WIDTH-1:0]  wr_eval;
    logic                          wr_capture;
    logic                          wr_done;
    logic                          am_idle;
    logic                          am_moves_ready;
    logic [MAX_POSITIONS_LOG2-1:0] am_move_count;
    logic [MAX_POSITIONS_LOG2-1:0] am_move_index;
    logic                          am_clear_moves;
    logic [`BOARD_WIDTH-1:0]       board_out;
    logic [UCI_WIDTH-1:0]          uci_out;
    logic signed [EVAL_WIDTH-1:0]  eval_out;
    logic                          capture_out;
    logic                          overflow;

    modport master (
        output list_start, wr_valid, wr_board, wr_uci, wr_eval,
        output wr_capture, wr_done, am_move_index, am_clear_moves,
        input  wr_ready, am_idle, am_moves_ready, am_move_count,
        input  board_out, uci_out, eval_out, capture_out, overflow
    );

    modport slave (
        input  list_start, wr_valid, wr_board, wr_uci, wr_eval,
        input  wr_capture, wr_done, am_move_index, am_clear_moves,
        output wr_ready, am_idle, am_moves_ready, am_move_count,
        output board_out, uci_out, eval_out, capture_out, overflow
    );
endinterface

// File: rtl/move_list_store.sv
// Move list buffer: filled by the generator, read back by index.
// Ports: clk, reset (sync, active-low), io_bus (slave modport).
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module move_list_store #(
    parameter int MAX_POSITIONS_LOG2 = 8,
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = 16
) (
    input  logic              clk,
    input  logic              reset,
    move_list_store_if.slave  io_bus
);
    localparam int N     = MAX_POSITIONS_LOG2;
    localparam int DEPTH = 1 << N;
    localparam int W     = `BOARD_WIDTH + UCI_WIDTH + EVAL_WIDTH + 1;

    localparam logic [N-1:0] LAST = {N{1'b1}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0]   r_state;
    logic [N-1:0] r_count;
    logic         r_overflow;
    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rd_data;
    logic         r_rd_ok;

    logic         w_fill;
    logic         w_full;
    logic         w_wr_ready;
    logic         w_wr;
    logic [W-1:0] w_wr_data;

    assign w_fill     = (r_state == FILL);
    // Last slot is never used so the count cannot wrap.
    assign w_full     = (r_count == LAST);
    assign w_wr_ready = w_fill && !w_full;
    // Abort wins over a write in the same cycle.
    assign w_wr       = w_wr_ready && io_bus.wr_valid
                        && !io_bus.am_clear_moves;
    assign w_wr_data  = {io_bus.wr_capture, io_bus.wr_eval,
                         io_bus.wr_uci, io_bus.wr_board};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.list_start) begin
                        r_state    <= FILL;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                FILL: begin
                    if (io_bus.am_clear_moves) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else begin
                        if (w_wr)
                            r_count <= r_count + 1'b1;
                        else if (io_bus.wr_valid)
                            r_overflow <= 1'b1;
                        if (io_bus.wr_done)
                            r_state <= READY;
                    end
                end
                READY: begin
                    if (io_bus.am_clear_moves) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Unreset storage and read register keep this a plain dual-port RAM.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_count] <= w_wr_data;
        r_rd_data <= r_mem[io_bus.am_move_index];
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_rd_ok <= 1'b0;
        else
            r_rd_ok <= (r_state == READY)
                       && (io_bus.am_move_index < r_count);
    end

    assign {io_bus.capture_out, io_bus.eval_out,
            io_bus.uci_out, io_bus.board_out} =
        r_rd_ok ? r_rd_data : '0;

    assign io_bus.wr_ready       = w_wr_ready;
    assign io_bus.am_idle        = (r_state == IDLE);
    assign io_bus.am_moves_ready = (r_state == READY);
    assign io_bus.am_move_count  = r_count;
    assign io_bus.overflow       = r_overflow;
endmodule

// File: tb/tb_move_list_store.sv
// Randomized and directed bench for move_list_store (depth 8).
// Reference model keeps the list as a queue.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module tb_move_list_store;
    localparam int N   = 3;
    localparam int EW  = 24;
    localparam int UW  = 16;
    localparam int BW  = `BOARD_WIDTH;
    localparam int W   = BW + UW + EW + 1;
    localparam int CAP = (1 << N) - 1;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_READY = 2;

    logic clk;
    logic reset;

    move_list_store_if #(
        .MAX_POSITIONS_LOG2(N),
        .EVAL_WIDTH(EW),
        .UCI_WIDTH(UW)
    ) bus ();

    move_list_store #(
        .MAX_POSITIONS_LOG2(N),
        .EVAL_WIDTH(EW),
        .UCI_WIDTH(UW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_chk;
    int           n_pass;
    int           m_st;
    bit           m_ov;
    logic [W-1:0] m_q[$];

    task automatic chk(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, obs, exp, $time);
    endtask

    function automatic logic [W-1:0] cur_entry();
        return {bus.wr_capture, bus.wr_eval, bus.wr_uci, bus.wr_board};
    endfunction

    // Model update for one clock edge from the inputs now applied.
    task automatic model_step();
        if (!reset) begin
            m_st = S_IDLE;
            m_q.delete();
            m_ov = 1'b0;
        end else if (m_st == S_IDLE) begin
            if (bus.list_start) begin
                m_st = S_FILL;
                m_q.delete();
                m_ov = 1'b0;
            end
        end else if (m_st == S_FILL) begin
            if (bus.am_clear_moves) begin
                m_st = S_IDLE;
                m_q.delete();
            end else begin
                if (bus.wr_valid) begin
                    if (m_q.size() < CAP)
                        m_q.push_back(cur_entry());
                    else
                        m_ov = 1'b1;
                end
                if (bus.wr_done)
                    m_st = S_READY;
            end
        end else begin
            if (bus.am_clear_moves) begin
                m_st = S_IDLE;
                m_q.delete();
            end
        end
    endtask

    task automatic cyc();
        logic [W-1:0] exp_rd;
        exp_rd = '0;
        if (reset && m_st == S_READY
            && int'(bus.am_move_index) < m_q.size())
            exp_rd = m_q[bus.am_move_index];
        @(posedge clk);
        model_step();
        #1;
        chk("idle", W'(bus.am_idle), W'(m_st == S_IDLE));
        chk("ready", W'(bus.am_moves_ready), W'(m_st == S_READY));
        chk("count", W'(bus.am_move_count), W'(m_q.size()));
        chk("overflow", W'(bus.overflow), W'(m_ov));
        chk("wr_ready", W'(bus.wr_ready),
            W'(m_st == S_FILL && m_q.size() < CAP));
        chk("rd_data", {bus.capture_out, bus.eval_out,
                        bus.uci_out, bus.board_out}, exp_rd);
    endtask

    task automatic rand_payload();
        for (int k = 0; k < BW / 32; k++)
            bus.wr_board[k*32 +: 32] = $urandom;
        bus.wr_uci     = UW'($urandom);
        bus.wr_eval    = EW'($urandom);
        bus.wr_capture = 1'($urandom);
    endtask

    task automatic wr(input logic [UW-1:0] uci,
                      input int ev);
        rand_payload();
        bus.wr_uci   = uci;
        bus.wr_eval  = EW'(ev);
        bus.wr_valid = 1'b1;
        cyc();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.list_start = 1'b1;
        cyc();
        bus.list_start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.wr_done = 1'b1;
        cyc();
        bus.wr_done = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.am_clear_moves = 1'b1;
        cyc();
        bus.am_clear_moves = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        m_st   = S_IDLE;
        m_ov   = 1'b0;
        reset  = 1'b0;
        bus.list_start     = 1'b0;
        bus.wr_valid       = 1'b0;
        bus.wr_board       = '0;
        bus.wr_uci         = '0;
        bus.wr_eval        = '0;
        bus.wr_capture     = 1'b0;
        bus.wr_done        = 1'b0;
        bus.am_move_index  = '0;
        bus.am_clear_moves = 1'b0;

        repeat (4) cyc();
        reset = 1'b1;

        // basic fill and read-back
        pulse_start();
        wr(16'h0C0C, 5);
        wr(16'h0E0E, -7);
        wr(16'h1C14, 100);
        pulse_done();
        for (int i = 0; i < 4; i++) begin
            bus.am_move_index = N'(i);
            cyc();
            if (i == 1)
                chk("eval_neg", W'(bus.eval_out), W'(EW'(-7)));
        end

        // ignored inputs
        pulse_start();
        pulse_clear();
        bus.wr_valid = 1'b1;
        cyc();
        bus.wr_valid = 1'b0;

        // full list
        pulse_start();
        for (int i = 0; i < 9; i++)
            wr(UW'($urandom), int'($urandom));
        pulse_done();
        for (int i = 7; i >= 0; i--) begin
            bus.am_move_index = N'(i);
            cyc();
        end
        pulse_clear();

        // write with done in same cycle
        pulse_start();
        wr(16'h1234, 1);
        bus.wr_done = 1'b1;
        wr(16'h5678, -2);
        bus.wr_done = 1'b0;
        bus.am_move_index = N'(1);
        cyc();
        pulse_clear();

        // abort from FILL beats done and write
        pulse_start();
        wr(16'h0101, 3);
        bus.wr_done = 1'b1;
        bus.am_clear_moves = 1'b1;
        wr(16'h0202, 4);
        bus.wr_done = 1'b0;
        bus.am_clear_moves = 1'b0;

        // reset in mid-fill, then empty list
        pulse_start();
        wr(16'h0303, 6);
        wr(16'h0404, 7);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        pulse_start();
        pulse_done();
        bus.am_move_index = '0;
        cyc();
        pulse_clear();

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            reset              = ($urandom_range(0, 199) != 0);
            bus.list_start     = ($urandom_range(0, 7) == 0);
            bus.wr_valid       = 1'($urandom);
            bus.wr_done        = ($urandom_range(0, 15) == 0);
            bus.am_clear_moves = ($urandom_range(0, 31) == 0);
            bus.am_move_index  = N'($urandom);
            rand_payload();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/move_list_store.md
MOVE_LIST_STORE -- requirements
Module: move_list_store

Parameters
REQ-001 SHALL have parameter MAX_POSITIONS_LOG2, default 8: log2 of list depth.
REQ-002 SHALL have parameter EVAL_WIDTH, default 24: signed evaluation width.
REQ-003 SHALL have parameter UCI_WIDTH, default 16: promotion[15:12], to[11:6], from[5:0].
REQ-004 SHALL take `BOARD_WIDTH from vchess.vh as the board entry width.

Interface
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port list_start, input, 1: pulse that opens a new list.
REQ-008 SHALL have port wr_valid, input, 1: generator offers one move.
REQ-009 SHALL have port wr_ready, output, 1: store accepts the offered move this cycle.
REQ-010 SHALL have ports wr_board, input, `BOARD_WIDTH; wr_uci, input, UCI_WIDTH; wr_eval, input, EVAL_WIDTH signed; wr_capture, input, 1: move payload.
REQ-011 SHALL have port wr_done, input, 1: generator has finished the list.
REQ-012 SHALL have port am_idle, output, 1: store is in IDLE.
REQ-013 SHALL have port am_moves_ready, output, 1: list is complete and readable.
REQ-014 SHALL have port am_move_count, output, MAX_POSITIONS_LOG2: number of stored moves.
REQ-015 SHALL have port am_move_index, input, MAX_POSITIONS_LOG2: read address.
REQ-016 SHALL have port am_clear_moves, input, 1: consumer releases the list.
REQ-017 SHALL have ports board_out, uci_out, eval_out, capture_out, outputs, same widths as the wr_* payload: registered read data.
REQ-018 SHALL have port overflow, output, 1: sticky flag, a write was dropped because the list was full.

Function
REQ-019 SHALL implement a three-state FSM with states IDLE, FILL and READY.
REQ-020 IDLE->FILL on list_start; on that edge the SHALL clear am_move_count and overflow to 0.
REQ-021 In FILL, when wr_valid && wr_ready, the store SHALL write the payload at address am_move_count and increment am_move_count by 1 on the next edge.
REQ-022 wr_ready SHALL equal (state==FILL) && (am_move_count != 2^MAX_POSITIONS_LOG2-1); capacity is 2^MAX_POSITIONS_LOG2-1 entries, and the count SHALL NOT wrap.
REQ-023 wr_valid while in FILL and full SHALL set overflow and drop the payload; the count SHALL stay unchanged.
REQ-024 FILL->READY on wr_done; a write accepted in the same cycle SHALL be stored and counted.
REQ-025 READY->IDLE on am_clear_moves; am_move_count SHALL become 0 on that edge.
REQ-026 am_clear_moves in FILL SHALL abort to IDLE with count 0; this has priority over wr_done and any write in that cycle.
REQ-027 list_start outside IDLE SHALL be ignored; wr_valid outside FILL SHALL be ignored and SHALL NOT set overflow.
REQ-028 am_idle and am_moves_ready SHALL be registered state decodes: am_idle=(state==IDLE), am_moves_ready=(state==READY).
REQ-029 Read latency SHALL be one cycle: the *_out signals at edge N+1 reflect the entry at the am_move_index sampled at edge N.
REQ-030 Reads SHALL be valid only while in READY; for am_move_index >= am_move_count, all *_out signals SHALL be 0.
REQ-031 Storage SHALL be inferable as simple dual-port block RAM, with the out-of-range zeroing done on a registered compare.

Reset
REQ-032 While reset==0 at a clock edge, the store SHALL enter IDLE with am_move_count=0, overflow=0, am_idle=1, am_moves_ready=0, wr_ready=0 and all *_out signals 0.
REQ-033 Reset SHALL override every other input, including in mid-FILL; RAM contents need not be cleared.

Verification
REQ-034 Basic fill and read: reset low for 4 cycles -> list_start -> 3 writes with uci 0x0C0C, 0x0E0E, 0x1C14 and evals 5, -7, 100 -> wr_done -> am_moves_ready=1 and count=3; index 0..2 returns each entry one cycle later, signed eval preserved.
REQ-035 Full list, MAX_POSITIONS_LOG2=3: 9 writes -> wr_ready drops after 7 accepted writes, count=7, overflow=1, index 7 reads as 0.
REQ-036 Simultaneous write and done: a write accepted with wr_done in the same cycle -> count includes it and the next cycle is READY.
REQ-037 Clear: am_clear_moves in READY -> am_idle=1 and count=0 next cycle; am_clear_moves in FILL with wr_done and wr_valid high -> IDLE, count=0, write not counted.
REQ-038 Reset mid-FILL after 2 writes -> IDLE, count=0; a subsequent list_start with zero writes and wr_done -> READY with count=0.
REQ-039 Ignored inputs: list_start in READY -> no change; wr_valid in IDLE -> overflow stays 0 and count stays 0.
